// File: rtl/divu_iter.sv
// -----------------------------------------------------------------------------
// divu_iter -- iterative unsigned restoring divider, one quotient bit per clock.
//
// Sits in front of the enable-gated execute-stage result registers: the ready
// pulse is their write enable, busy is the stall term for upstream enables.
//
// Handshake: start is sampled on a rising edge of clk while the divider is in
// IDLE or DONE; it is ignored (not queued) while busy is high. Exactly one
// ready pulse follows each accepted start unless clr aborts the operation.
// q/r/divzero are valid during the ready cycle and hold until the next
// completion or clr.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset, priority over start
//   start      request a division (accepted in IDLE/DONE)
//   a, b       dividend / divisor, captured with an accepted start
//   q, r       registered quotient / remainder
//   busy       high in every RUN cycle
//   ready      one-cycle completion pulse
//   divzero    registered; completed division had b == 0
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             divzero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qw_q, qw_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;    // working remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;    // captured divisor
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             dz_q, dz_d;

    // One restoring step. trial[WIDTH] set means the subtraction went negative.
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] qw_step;
    logic [WIDTH-1:0] rem_step;

    always_comb begin
        trial    = {rem_q, qw_q[WIDTH-1]} - {1'b0, dvs_q};
        qw_step  = {qw_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_step = trial[WIDTH] ? {rem_q[WIDTH-2:0], qw_q[WIDTH-1]}
                                : trial[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qw_d    = qw_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    qw_d  = a;
                    dvs_d = b;
                    rem_d = '0;
                    cnt_d = '0;
                    if (b != '0) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end else begin
                        // Divide by zero completes on the accepting edge.
                        q_d     = '1;
                        r_d     = a;
                        dz_d    = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                qw_d  = qw_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    q_d     = qw_step;
                    r_d     = rem_step;
                    dz_d    = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qw_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qw_q    <= qw_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            dz_q    <= dz_d;
        end
    end

    assign q         = q_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign divzero   = dz_q;
    assign dbg_state = state_q;

endmodule
